// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter serializing NUM_REQ write sources onto one register-file write port.
// Grant to o_w_en is one cycle. Each write holds off arbitration for W_EN_LEN+GAP_LEN cycles. Requests are level-held until o_ack.
module reg_write_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int W_EN_LEN = 1,
    parameter int GAP_LEN  = 1,
    localparam int GW      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_data,
    output logic [NUM_REQ-1:0]        o_ack,
    output logic                      o_busy,
    output logic [GW-1:0]             o_grant_id,
    output logic [ADDR_W-1:0]         o_w_addr,
    output logic [DATA_W-1:0]         o_w_data,
    output logic                      o_w_en
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam int MAXL = (W_EN_LEN > GAP_LEN) ? W_EN_LEN : GAP_LEN;
    localparam int CW   = $clog2(MAXL + 1);
    localparam logic [CW-1:0] W_LAST = CW'(W_EN_LEN - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_LEN - 1);

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [GW-1:0]     r_grant_id;
    logic [GW-1:0]     r_last_grant;
    logic [ADDR_W-1:0] r_w_addr;
    logic [DATA_W-1:0] r_w_data;

    logic              w_found;
    logic [GW-1:0]     w_win;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_ack_now;
    int                w_dist;
    int                w_best;

    // Winner is the set request with the smallest rotational distance past last_grant.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_dist     = 0;
        w_best     = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = j - int'(r_last_grant) - 1;
            if (w_dist < 0) w_dist = w_dist + NUM_REQ;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_found    = 1'b1;
                w_win      = GW'(j);
                w_sel_addr = i_addr[j*ADDR_W +: ADDR_W];
                w_sel_data = i_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_grant_id   <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_w_addr     <= '0;
            r_w_data     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state      <= S_WRITE;
                        r_cnt        <= '0;
                        r_grant_id   <= w_win;
                        r_last_grant <= w_win;
                        r_w_addr     <= w_sel_addr;
                        r_w_data     <= w_sel_data;
                    end
                end
                S_WRITE: begin
                    if (r_cnt == W_LAST) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == G_LAST) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Ack fires in the first GAP cycle, i.e. once the full enable pulse has been driven.
    assign w_ack_now = (r_state == S_GAP) && (r_cnt == '0);

    always_comb begin
        o_ack = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            o_ack[j] = w_ack_now && (r_grant_id == GW'(j));
        end
    end

    assign o_w_en     = (r_state == S_WRITE);
    assign o_busy     = (r_state != S_IDLE);
    assign o_grant_id = r_grant_id;
    assign o_w_addr   = r_w_addr;
    assign o_w_data   = r_w_data;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench: dut uses 1-cycle pulse / 1-cycle gap, dut4 uses 4-cycle pulse / 2-cycle gap.
module tb_reg_write_arbiter;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst,  rst4;
    logic [1:0]  req,  req4;
    logic [15:0] addr, addr4;
    logic [63:0] data, data4;
    logic [1:0]  ack,  ack4;
    logic        busy, busy4, wen, wen4;
    logic        gid,  gid4;
    logic [7:0]  waddr, waddr4;
    logic [31:0] wdata, wdata4;

    int n_tests = 0;
    int n_fail  = 0;

    reg_write_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32), .W_EN_LEN(1), .GAP_LEN(1)) dut (
        .clk(clk), .i_reset(rst), .i_req(req), .i_addr(addr), .i_data(data),
        .o_ack(ack), .o_busy(busy), .o_grant_id(gid),
        .o_w_addr(waddr), .o_w_data(wdata), .o_w_en(wen));

    reg_write_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(32), .W_EN_LEN(4), .GAP_LEN(2)) dut4 (
        .clk(clk), .i_reset(rst4), .i_req(req4), .i_addr(addr4), .i_data(data4),
        .o_ack(ack4), .o_busy(busy4), .o_grant_id(gid4),
        .o_w_addr(waddr4), .o_w_data(wdata4), .o_w_en(wen4));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst4 = 1'b1;
        req = '0; addr = '0; data = '0;
        req4 = '0; addr4 = '0; data4 = '0;
        tick(); tick();
        rst = 1'b0; rst4 = 1'b0;

        // Reset state
        chk("rst_wen",   wen,   1'b0);
        chk("rst_ack",   ack,   2'b00);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_gid",   gid,   1'b0);
        chk("rst_waddr", waddr, 8'h00);
        chk("rst_wdata", wdata, 32'h0);

        // Single write from requester 0
        req = 2'b01; addr[7:0] = 8'h12; data[31:0] = 32'h01233456;
        chk("sw_idle_wen", wen, 1'b0);
        tick();
        chk("sw_wen",   wen,   1'b1);
        chk("sw_addr",  waddr, 8'h12);
        chk("sw_data",  wdata, 32'h01233456);
        chk("sw_gid",   gid,   1'b0);
        chk("sw_busy",  busy,  1'b1);
        chk("sw_noack", ack,   2'b00);
        tick();
        chk("sw_wen_off", wen, 1'b0);
        chk("sw_ack",   ack,   2'b01);
        chk("sw_busy2", busy,  1'b1);
        req = 2'b00;
        tick();
        chk("sw_idle_busy", busy, 1'b0);
        chk("sw_idle_ack",  ack,  2'b00);
        chk("sw_hold_addr", waddr, 8'h12);

        // Simultaneous requests after a fresh reset: 0 then 1, starts 3 cycles apart
        rst = 1'b1; tick(); rst = 1'b0;
        req = 2'b11;
        addr = {8'h20, 8'h10}; data = {32'hBBBB1111, 32'hAAAA0000};
        tick();
        chk("sim_wen0",  wen,   1'b1);
        chk("sim_addr0", waddr, 8'h10);
        chk("sim_data0", wdata, 32'hAAAA0000);
        tick();
        chk("sim_ack0",  ack,   2'b01);
        req[0] = 1'b0;
        tick();
        chk("sim_idle_wen", wen, 1'b0);
        chk("sim_idle_busy", busy, 1'b0);
        tick();
        chk("sim_wen1",  wen,   1'b1);
        chk("sim_addr1", waddr, 8'h20);
        chk("sim_data1", wdata, 32'hBBBB1111);
        chk("sim_gid1",  gid,   1'b1);
        tick();
        chk("sim_ack1",  ack,   2'b10);
        req[1] = 1'b0;
        tick();
        chk("sim_done_busy", busy, 1'b0);

        // Fairness: both re-request right after each ack
        addr = {8'h31, 8'h30};
        req  = 2'b11;
        for (int n = 0; n < 6; n++) begin
            logic       e;
            logic [7:0] ea;
            e  = n[0];
            ea = e ? 8'h31 : 8'h30;
            tick();
            chk("fair_wen",  wen,   1'b1);
            chk("fair_gid",  gid,   e);
            chk("fair_addr", waddr, ea);
            tick();
            chk("fair_ack",  ack,   e ? 2'b10 : 2'b01);
            req[e] = 1'b0;
            tick();
            chk("fair_idle", busy,  1'b0);
            req[e] = 1'b1;
        end
        req = 2'b00;

        // Long pulse on dut4: requester 1
        req4 = 2'b10; addr4[15:8] = 8'h7F; data4[63:32] = 32'hDEADBEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("lp_wen",  wen4,   1'b1);
            chk("lp_addr", waddr4, 8'h7F);
            chk("lp_data", wdata4, 32'hDEADBEEF);
            chk("lp_noack", ack4,  2'b00);
        end
        tick();
        chk("lp_wen_off", wen4, 1'b0);
        chk("lp_ack",  ack4,  2'b10);
        req4 = 2'b00;
        tick();
        chk("lp_gap2_busy", busy4, 1'b1);
        chk("lp_gap2_ack",  ack4,  2'b00);
        tick();
        chk("lp_idle_busy", busy4, 1'b0);

        // Input change after grant on dut4: requester 0
        req4 = 2'b01; addr4[7:0] = 8'h12; data4[31:0] = 32'h01233456;
        tick();
        chk("ic_wen0", wen4, 1'b1);
        data4[31:0] = 32'h0;
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("ic_wen",  wen4,   1'b1);
            chk("ic_data", wdata4, 32'h01233456);
        end
        tick();
        chk("ic_ack", ack4, 2'b01);
        req4 = 2'b00;
        tick(); tick();
        chk("ic_idle", busy4, 1'b0);

        // Reset mid-write on dut4: requester 0 again, reset on the 2nd enable cycle
        req4 = 2'b01; addr4[7:0] = 8'h55; data4[31:0] = 32'h12345678;
        tick();
        chk("rm_wen1", wen4, 1'b1);
        tick();
        chk("rm_wen2", wen4, 1'b1);
        rst4 = 1'b1;
        tick();
        chk("rm_wen_off", wen4,   1'b0);
        chk("rm_noack",   ack4,   2'b00);
        chk("rm_busy",    busy4,  1'b0);
        chk("rm_waddr",   waddr4, 8'h00);
        rst4 = 1'b0;
        req4 = 2'b11; addr4 = {8'h66, 8'h55};
        tick();
        chk("rm_regrant_gid",  gid4,   1'b0);
        chk("rm_regrant_addr", waddr4, 8'h55);
        for (int c = 0; c < 8; c++) begin
            if (ack4 != 2'b00) req4 = req4 & ~ack4;
            tick();
        end
        req4 = 2'b00;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
